reg_write_arbiter: RTL and testbench



---
 rtl/reg_arb_pkg.sv | 15 +
 rtl/shared_reg.sv | 25 ++
 rtl/reg_write_arbiter.sv | 116 +++++++++++
 tb/tb_reg_write_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// FSM state encoding and default geometry.
package reg_arb_pkg;

   localparam int N_DEF = 4;
   localparam int W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_WRITE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/shared_reg.sv
// W-bit storage register with load enable; its contents clear
// asynchronously on rst.
module shared_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_data;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that serialises N requesters onto one shared
// register: IDLE -> GRANT -> WRITE -> DONE, one write per four cycles.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] wdata,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   ack,
   output logic [W-1:0]   q,
   output logic           busy
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_t          r_state;
   logic [IW-1:0]   r_win;
   logic [IW-1:0]   r_last;
   logic [N-1:0]    r_gnt;
   logic [N-1:0]    r_ack;
   logic            r_busy;

   logic [IW-1:0]   w_pick;
   logic [IW-1:0]   w_cand;
   int              w_idx;
   logic            w_load;
   logic [W-1:0]    w_wdata_sel;

   // Walk from the farthest candidate back to last+1 so the nearest
   // set request after the previous winner overwrites the others.
   always_comb begin
      w_pick = r_last;
      w_cand = '0;
      w_idx  = 0;
      for (int k = N; k >= 1; k--) begin
         w_idx = int'(r_last) + k;
         if (w_idx >= N) begin
            w_idx = w_idx - N;
         end
         w_cand = IW'(w_idx);
         if (req[w_cand]) begin
            w_pick = w_cand;
         end
      end
   end

   assign w_load      = (r_state == ST_WRITE);
   assign w_wdata_sel = wdata[int'(r_win)*W +: W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_win   <= '0;
         r_last  <= IW'(N-1);
         r_gnt   <= '0;
         r_ack   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_win   <= w_pick;
                  r_gnt   <= N'(1) << w_pick;
                  r_busy  <= 1'b1;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // A request dropped before WRITE is an abort: the pointer
               // is left alone so the same priority order applies again.
               if (req[r_win]) begin
                  r_state <= ST_WRITE;
               end else begin
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_WRITE: begin
               r_gnt   <= '0;
               r_ack   <= N'(1) << r_win;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_ack   <= '0;
               r_last  <= r_win;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   shared_reg #(
      .W (W)
   ) u_shared_reg (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_data (w_wdata_sel),
      .o_q    (q)
   );

   assign gnt  = r_gnt;
   assign ack  = r_ack;
   assign busy = r_busy;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (N=4, W=8): reset, single write,
// async reset mid-write, abort, contention, held and late requests.
module tb_reg_write_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic [7:0]  q;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] lanes [4];

   reg_write_arbiter #(
      .N (4),
      .W (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .ack   (ack),
      .q     (q),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   initial begin
      lanes[0] = 8'hA0;
      lanes[1] = 8'hB1;
      lanes[2] = 8'hC2;
      lanes[3] = 8'hD3;

      // Power-on reset
      rst   = 1'b1;
      req   = 4'b0000;
      wdata = 32'h0;
      #12;
      chk("rst_q",    32'(q),    32'h00);
      chk("rst_gnt",  32'(gnt),  32'h0);
      chk("rst_ack",  32'(ack),  32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      step();

      // Single request from requester 2
      req   = 4'b0100;
      wdata = 32'h00A5_0000;
      step();
      chk("single_gnt_e0",  32'(gnt),  32'h4);
      chk("single_busy_e0", 32'(busy), 32'h1);
      chk("single_ack_e0",  32'(ack),  32'h0);
      step();
      chk("single_gnt_e1",  32'(gnt),  32'h4);
      chk("single_q_e1",    32'(q),    32'h00);
      step();
      chk("single_q_e2",    32'(q),    32'hA5);
      chk("single_ack_e2",  32'(ack),  32'h4);
      chk("single_gnt_e2",  32'(gnt),  32'h0);
      req = 4'b0000;
      step();
      chk("single_ack_e3",  32'(ack),  32'h0);
      chk("single_busy_e3", 32'(busy), 32'h0);

      // Reset asserted while requester 3 is in WRITE
      req   = 4'b1000;
      wdata = 32'hFF00_0000;
      step();
      chk("rstw_gnt_e0", 32'(gnt), 32'h8);
      step();
      rst = 1'b1;
      #1;
      chk("rstw_q",    32'(q),    32'h00);
      chk("rstw_gnt",  32'(gnt),  32'h0);
      chk("rstw_ack",  32'(ack),  32'h0);
      chk("rstw_busy", 32'(busy), 32'h0);
      req   = 4'b1001;
      wdata = 32'hFF00_003C;
      #1;
      rst = 1'b0;
      step();
      chk("rstw_first_gnt", 32'(gnt), 32'h1);
      step();
      step();
      chk("rstw_ack0", 32'(ack), 32'h1);
      chk("rstw_q0",   32'(q),   32'h3C);
      req = 4'b1000;
      step();
      step();
      chk("rstw_gnt3", 32'(gnt), 32'h8);
      step();
      step();
      chk("rstw_ack3", 32'(ack), 32'h8);
      chk("rstw_q3",   32'(q),   32'hFF);
      req = 4'b0000;
      step();
      chk("rstw_busy_end", 32'(busy), 32'h0);

      // Abort: requester 1 drops its request while in GRANT
      req = 4'b0010;
      step();
      chk("abort_gnt", 32'(gnt), 32'h2);
      req = 4'b0000;
      step();
      chk("abort_gnt_clr", 32'(gnt),  32'h0);
      chk("abort_busy",    32'(busy), 32'h0);
      step();
      chk("abort_ack", 32'(ack), 32'h0);
      chk("abort_q",   32'(q),   32'hFF);

      // Contention: all four request; pointer still at 3, so order 0,1,2,3,0
      wdata = {lanes[3], lanes[2], lanes[1], lanes[0]};
      req   = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("cont_gnt_%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
         step();
         step();
         chk($sformatf("cont_ack_%0d", k), 32'(ack), 32'(4'b0001 << (k % 4)));
         chk($sformatf("cont_q_%0d", k),   32'(q),   32'(lanes[k % 4]));
         req[k % 4] = 1'b0;
         step();
         chk($sformatf("cont_ack_clr_%0d", k), 32'(ack), 32'h0);
         req[k % 4] = 1'b1;
      end
      req = 4'b0000;
      step();

      // Held request: requester 2 keeps req high, requester 3 goes next
      req = 4'b1100;
      step();
      chk("held_gnt2", 32'(gnt), 32'h4);
      step();
      step();
      chk("held_ack2", 32'(ack), 32'h4);
      chk("held_q2",   32'(q),   32'hC2);
      step();
      step();
      chk("held_gnt3", 32'(gnt), 32'h8);
      step();
      step();
      chk("held_ack3", 32'(ack), 32'h8);
      chk("held_q3",   32'(q),   32'hD3);
      req = 4'b0000;
      step();

      // Late arrival: requester 3 raises during requester 0's WRITE
      req = 4'b0001;
      step();
      chk("late_gnt0", 32'(gnt), 32'h1);
      step();
      req = 4'b1001;
      step();
      chk("late_ack0",  32'(ack), 32'h1);
      chk("late_q0",    32'(q),   32'hA0);
      chk("late_gnt_d", 32'(gnt), 32'h0);
      req = 4'b1000;
      step();
      chk("late_gnt_idle", 32'(gnt), 32'h0);
      step();
      chk("late_gnt3", 32'(gnt), 32'h8);
      step();
      step();
      chk("late_ack3", 32'(ack), 32'h8);
      chk("late_q3",   32'(q),   32'hD3);
      req = 4'b0000;
      step();
      chk("late_busy_end", 32'(busy), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
